// File: rtl/proj_pkg.sv
// Shared sizing and state encoding for the FM signature buffer read side.
package proj_pkg;

  localparam int unsigned FM_BUFFER_SIZE = 16;
  localparam int unsigned FM_DATA_W      = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } fm_rd_state_t;

endpackage

// File: rtl/proj_fm_skid_fifo.sv
// Two-entry FIFO that buffers RAM read data ahead of the valid/ready output.
module proj_fm_skid_fifo #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/proj_fm_reader.sv
// Sweeps the FM buffer in address order, streams each entry over valid/ready
// and records the minimum entry of the sweep.
module proj_fm_reader #(
  parameter int unsigned FM_BUFFER_SIZE = proj_pkg::FM_BUFFER_SIZE,
  parameter int unsigned DATA_W         = proj_pkg::FM_DATA_W,
  parameter int unsigned ADDR_W         = $clog2(FM_BUFFER_SIZE)
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] min_value,
  output logic              start_err
);

  import proj_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FM_BUFFER_SIZE - 1);

  fm_rd_state_t      state;
  logic              rd_pending;
  logic              rd_pending_last;
  logic [1:0]        fifo_count;
  logic [DATA_W:0]   fifo_head;
  logic              handshake;
  logic [2:0]        credits_used;
  logic              last_out;
  logic [DATA_W-1:0] run_min;
  logic [DATA_W-1:0] run_min_next;

  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_head[DATA_W-1:0];
  assign out_last  = out_valid & fifo_head[DATA_W];

  // Credits count words already buffered or in flight, net of this cycle's pop,
  // so a steady ready stream still issues one read per cycle.
  always_comb begin
    handshake    = out_valid & out_ready;
    credits_used = {1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, handshake};
    rd_en        = (state == READ) && (credits_used < 3'd2);
    last_out     = !rd_pending && ((fifo_count == 2'd0) || (fifo_count == 2'd1 && handshake));
    run_min_next = (handshake && (out_data < run_min)) ? out_data : run_min;
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state           <= IDLE;
      rd_addr         <= '0;
      rd_pending      <= 1'b0;
      rd_pending_last <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      start_err       <= 1'b0;
      min_value       <= '1;
      run_min         <= '1;
    end else begin
      rd_pending      <= rd_en;
      rd_pending_last <= rd_en && (rd_addr == LAST_ADDR);
      done            <= 1'b0;
      start_err       <= start && (state != IDLE);
      run_min         <= run_min_next;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= READ;
            busy    <= 1'b1;
            rd_addr <= '0;
            run_min <= '1;
          end
        end
        READ: begin
          if (rd_en) begin
            if (rd_addr == LAST_ADDR) begin
              state <= DRAIN;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Fold in the final word's compare on the same edge it is accepted.
          if (last_out) begin
            state     <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            min_value <= run_min_next;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  proj_fm_skid_fifo #(
    .WIDTH(DATA_W + 1)
  ) u_fifo (
    .clk      (in_clk),
    .rst      (in_rst),
    .push     (rd_pending),
    .push_data({rd_pending_last, rd_data}),
    .pop      (handshake),
    .head     (fifo_head),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_proj_fm_reader.sv
// Randomized bench for proj_fm_reader against a RAM model and a sweep-level reference.
module tb_proj_fm_reader;

  localparam int N = 16;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        start;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [31:0] min_value;
  logic        start_err;

  logic [31:0] ram [N];

  int n_checks = 0;
  int n_errors = 0;

  // Monitor bookkeeping, owned by the single stimulus process.
  int          issued;
  int          hs_cnt;
  int          done_cnt;
  int          serr_cnt;
  bit          hold_chk;
  logic [31:0] hold_data;
  logic        hold_last;
  logic [31:0] exp_min_prev;

  proj_fm_reader dut (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .start    (start),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .done     (done),
    .min_value(min_value),
    .start_err(start_err)
  );

  always #5 in_clk = ~in_clk;

  always @(posedge in_clk) begin
    if (rd_en) rd_data <= ram[rd_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_min();
    logic [31:0] m = 32'hFFFF_FFFF;
    for (int i = 0; i < N; i++) if (ram[i] < m) m = ram[i];
    return m;
  endfunction

  function automatic logic pick_ready(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      2:       return ($urandom % 4) != 0;
      default: return cyc >= 20;
    endcase
  endfunction

  // One clock: observe at the falling edge, then return just after the rising edge.
  task automatic tick();
    logic hs;
    @(negedge in_clk);
    if (!in_rst) begin
      hs = out_valid && out_ready;
      if (hold_chk) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
        check("hold_last", out_last, hold_last);
      end
      if (rd_en) begin
        check("rd_addr", rd_addr, issued);
        issued++;
        check("credit", (issued - hs_cnt - int'(hs)) <= 2, 1);
      end
      if (hs) begin
        if (hs_cnt < N) begin
          check("data", out_data, ram[hs_cnt]);
          check("last", out_last, hs_cnt == N - 1);
        end else begin
          check("extra_word", hs_cnt, N - 1);
        end
        hs_cnt++;
      end
      if (done) begin
        done_cnt++;
        check("busy_with_done", busy, 0);
      end
      if (start_err) serr_cnt++;
      hold_chk  = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
    end
    @(posedge in_clk);
    #1;
  endtask

  task automatic clear_mon();
    issued = 0; hs_cnt = 0; done_cnt = 0; serr_cnt = 0; hold_chk = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_start_err"}, start_err, 0);
    check({tag, "_min"}, min_value, 32'hFFFF_FFFF);
  endtask

  task automatic sweep(input int mode, input int restart_at, input int exp_serr);
    bit seen = 0;
    bit restarted = 0;
    check("min_hold", min_value, exp_min_prev);
    clear_mon();
    start = 1'b1;
    out_ready = pick_ready(mode, 0);
    @(posedge in_clk);
    #1;
    start = 1'b0;
    check("lat_rd_en", rd_en, 1);
    check("lat_addr", rd_addr, 0);
    check("lat_busy", busy, 1);
    for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
      out_ready = pick_ready(mode, cyc);
      start = (restart_at >= 0) && !restarted && (hs_cnt == restart_at);
      if (start) restarted = 1;
      if (mode == 3 && cyc == 20) begin
        check("stall_reads", issued, 2);
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, ram[0]);
      end
      tick();
      start = 1'b0;
      if (cyc == 0) check("lat_valid0", out_valid, 0);
      if (cyc == 1) check("lat_valid1", out_valid, 1);
      if (done) begin
        seen = 1;
        if (mode == 0) check("done_cycle", cyc, 17);
      end
    end
    check("done_seen", seen, 1);
    tick();
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
    check("words", hs_cnt, N);
    check("reads", issued, N);
    check("done_cnt", done_cnt, 1);
    check("start_err_cnt", serr_cnt, exp_serr);
    exp_min_prev = ref_min();
    check("min_value", min_value, exp_min_prev);
  endtask

  task automatic mid_reset();
    bit reached = 0;
    clear_mon();
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge in_clk);
    #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 100 && !reached; cyc++) begin
      tick();
      if (hs_cnt == 7) reached = 1;
    end
    check("reached_7", hs_cnt, 7);
    in_rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    check("midrst_no_done", done_cnt, 0);
    tick();
    tick();
    in_rst = 1'b0;
    exp_min_prev = 32'hFFFF_FFFF;
    check("post_rst_min", min_value, 32'hFFFF_FFFF);
  endtask

  initial begin
    in_rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    clear_mon();
    exp_min_prev = 32'hFFFF_FFFF;
    #2;
    check_reset_outputs("reset");
    @(posedge in_clk);
    #1;
    in_rst = 1'b0;
    tick();

    for (int i = 0; i < N; i++) ram[i] = i * 3 + 5;
    sweep(0, -1, 0);

    for (int i = 0; i < N; i++) ram[i] = 100 - i;
    sweep(1, -1, 0);

    for (int i = 0; i < N; i++) ram[i] = $urandom;
    sweep(0, 4, 1);

    mid_reset();
    for (int i = 0; i < N; i++) ram[i] = $urandom;
    sweep(0, -1, 0);

    for (int i = 0; i < N; i++) ram[i] = 32'hFFFF_FFFF;
    ram[9] = 32'h0000_0007;
    sweep(2, -1, 0);
    for (int i = 0; i < N; i++) ram[i] = 32'hFFFF_FFFF;
    sweep(0, -1, 0);

    for (int i = 0; i < N; i++) ram[i] = $urandom;
    sweep(3, -1, 0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) ram[i] = $urandom_range(1000, 0);
      sweep(2, -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
